// File: rtl/oflow_score_board_pkg.sv
// Shared types and sizing for the overflow score board: board geometry, field widths,
// controller states and the stored entry layout.
package oflow_score_board_pkg;

    localparam int MAX_ROWS_IN_SCORE_BOARD = 3;
    localparam int PE_NUM                  = 3;
    localparam int ROW_LEN                 = 2;
    localparam int PE_LEN                  = 2;
    localparam int SCORE_LEN               = 8;
    localparam int ID_LEN                  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RESOLVE,
        ST_DRAIN
    } sb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [SCORE_LEN-1:0] score;
        logic [ID_LEN-1:0]    id;
        logic                 pointer;
    } sb_entry_t;

endpackage

// File: rtl/oflow_score_board_drain.sv
// Row-major drain of the score board: a linear scan counter walks every entry and
// valid ones are presented through a valid/ready output register.
module oflow_score_board_drain
    import oflow_score_board_pkg::*;
#(
    parameter int ROWS = MAX_ROWS_IN_SCORE_BOARD,
    parameter int PES  = PE_NUM
) (
    input  logic                 clk,
    input  logic                 reset_N,
    input  logic                 active_i,
    input  sb_entry_t            entry_i,
    input  logic [ROWS*PES-1:0]  vld_vec_i,
    input  logic                 out_ready_i,
    output logic [ROW_LEN-1:0]   scan_row_o,
    output logic [PE_LEN-1:0]    scan_pe_o,
    output logic                 out_valid_o,
    output logic                 out_last_o,
    output logic [ROW_LEN-1:0]   out_row_o,
    output logic [PE_LEN-1:0]    out_pe_o,
    output logic [SCORE_LEN-1:0] out_score_o,
    output logic [ID_LEN-1:0]    out_id_o,
    output logic                 out_pointer_o,
    output logic                 done_o
);

    localparam int N  = ROWS * PES;
    localparam int CW = ROW_LEN + PE_LEN;
    localparam logic [CW-1:0] END_CNT = CW'(N);

    logic [CW-1:0]      cnt_q;
    logic [ROW_LEN-1:0] row_q;
    logic [PE_LEN-1:0]  pe_q;
    logic               ov_q, ov_d;
    logic               last_q, last_d;
    logic               hs, hs_last, adv, load;

    function automatic logic any_after(input logic [N-1:0] v, input logic [CW-1:0] idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i > int'(idx) && v[i]) r = 1'b1;
        end
        return r;
    endfunction

    // The scan stalls while an entry is waiting for out_ready and stops for good at END_CNT.
    always_comb begin
        hs      = ov_q && out_ready_i;
        hs_last = hs && last_q;
        adv     = active_i && (cnt_q != END_CNT) && (!ov_q || out_ready_i) && !hs_last;
        load    = adv && entry_i.valid;
        ov_d    = ov_q;
        last_d  = last_q;
        if (load) begin
            ov_d   = 1'b1;
            last_d = !any_after(vld_vec_i, cnt_q);
        end else if (hs) begin
            ov_d   = 1'b0;
            last_d = 1'b0;
        end
        done_o = active_i && (hs_last || (cnt_q == END_CNT && !ov_q));
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            cnt_q  <= '0;
            row_q  <= '0;
            pe_q   <= '0;
            ov_q   <= 1'b0;
            last_q <= 1'b0;
        end else if (!active_i) begin
            cnt_q  <= '0;
            row_q  <= '0;
            pe_q   <= '0;
            ov_q   <= 1'b0;
            last_q <= 1'b0;
        end else begin
            if (adv) begin
                cnt_q <= cnt_q + 1'b1;
                if (pe_q == PE_LEN'(PES - 1)) begin
                    pe_q  <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    pe_q <= pe_q + 1'b1;
                end
            end
            ov_q   <= ov_d;
            last_q <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            out_row_o     <= row_q;
            out_pe_o      <= pe_q;
            out_score_o   <= entry_i.score;
            out_id_o      <= entry_i.id;
            out_pointer_o <= entry_i.pointer;
        end
    end

    assign scan_row_o  = row_q;
    assign scan_pe_o   = pe_q;
    assign out_valid_o = ov_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/oflow_score_board.sv
// Score board holding PE results between fill, conflict resolution and drain,
// sequenced by a four-state controller.
module oflow_score_board
    import oflow_score_board_pkg::*;
#(
    parameter int ROWS = MAX_ROWS_IN_SCORE_BOARD,
    parameter int PES  = PE_NUM
) (
    input  logic                 clk,
    input  logic                 reset_N,
    input  logic                 start_fill,
    input  logic                 wr_valid,
    input  logic [ROW_LEN-1:0]   wr_row,
    input  logic [PE_LEN-1:0]    wr_pe,
    input  logic [SCORE_LEN-1:0] wr_score,
    input  logic [ID_LEN-1:0]    wr_id,
    input  logic                 fill_done,
    output logic                 start_cr,
    input  logic [ROW_LEN-1:0]   row_sel,
    input  logic [PE_LEN-1:0]    pe_sel,
    output logic [SCORE_LEN-1:0] score_to_cr,
    output logic [ID_LEN-1:0]    id_to_cr,
    input  logic [ROW_LEN-1:0]   row_to_change,
    input  logic [PE_LEN-1:0]    pe_to_change,
    input  logic                 data_to_score_board_from_cr_pointer,
    input  logic                 write_to_pointer,
    input  logic [ID_LEN-1:0]    data_to_score_board_from_cr_id,
    input  logic                 write_to_id,
    input  logic                 done_cr,
    input  logic                 conflict_counter_th,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROW_LEN-1:0]   out_row,
    output logic [PE_LEN-1:0]    out_pe,
    output logic [SCORE_LEN-1:0] out_score,
    output logic [ID_LEN-1:0]    out_id,
    output logic                 out_pointer,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overflow_err
);

    localparam int N = ROWS * PES;

    sb_state_e            state_q, state_d;
    logic                 start_cr_q, ovf_q;
    logic                 vld_q   [ROWS][PES];
    logic                 ptr_q   [ROWS][PES];
    logic [SCORE_LEN-1:0] score_q [ROWS][PES];
    logic [ID_LEN-1:0]    id_q    [ROWS][PES];
    logic                 fill_go, wr_hit, cr_hit, rd_hit, drain_done;
    logic [N-1:0]         vld_vec;
    sb_entry_t            dr_ent;
    logic [ROW_LEN-1:0]   scan_row;
    logic [PE_LEN-1:0]    scan_pe;

    function automatic logic in_range(input logic [ROW_LEN-1:0] r, input logic [PE_LEN-1:0] p);
        return (int'(r) < ROWS) && (int'(p) < PES);
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_fill) state_d = ST_FILL;
            ST_FILL:    if (fill_done) state_d = ST_RESOLVE;
            ST_RESOLVE: if (done_cr) state_d = conflict_counter_th ? ST_IDLE : ST_DRAIN;
            ST_DRAIN:   if (drain_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q    <= ST_IDLE;
            start_cr_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_cr_q <= (state_q == ST_FILL) && fill_done;
            if (fill_go) begin
                ovf_q <= 1'b0;
            end else if (state_q == ST_RESOLVE && done_cr && conflict_counter_th) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // CR write-backs only touch entries that were filled in this pass.
    always_comb begin
        fill_go = (state_q == ST_IDLE) && start_fill;
        wr_hit  = (state_q == ST_FILL) && wr_valid && in_range(wr_row, wr_pe);
        cr_hit  = (state_q == ST_RESOLVE) && in_range(row_to_change, pe_to_change)
                  && vld_q[row_to_change][pe_to_change];
        rd_hit  = in_range(row_sel, pe_sel) && vld_q[row_sel][pe_sel];
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N || fill_go) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int p = 0; p < PES; p++) begin
                    vld_q[r][p] <= 1'b0;
                    ptr_q[r][p] <= 1'b0;
                end
            end
        end else begin
            if (wr_hit) begin
                vld_q[wr_row][wr_pe] <= 1'b1;
                ptr_q[wr_row][wr_pe] <= 1'b0;
            end
            if (cr_hit && write_to_pointer) begin
                ptr_q[row_to_change][pe_to_change] <= data_to_score_board_from_cr_pointer;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_hit) begin
            score_q[wr_row][wr_pe] <= wr_score;
            id_q[wr_row][wr_pe]    <= wr_id;
        end
        if (cr_hit && write_to_id) begin
            id_q[row_to_change][pe_to_change] <= data_to_score_board_from_cr_id;
        end
    end

    always_comb begin
        score_to_cr = rd_hit ? score_q[row_sel][pe_sel] : '1;
        id_to_cr    = rd_hit ? id_q[row_sel][pe_sel] : '0;
        vld_vec     = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int p = 0; p < PES; p++) begin
                vld_vec[r*PES + p] = vld_q[r][p];
            end
        end
        dr_ent = '0;
        if (in_range(scan_row, scan_pe)) begin
            dr_ent.valid   = vld_q[scan_row][scan_pe];
            dr_ent.score   = score_q[scan_row][scan_pe];
            dr_ent.id      = id_q[scan_row][scan_pe];
            dr_ent.pointer = ptr_q[scan_row][scan_pe];
        end
    end

    oflow_score_board_drain #(
        .ROWS (ROWS),
        .PES  (PES)
    ) u_drain (
        .clk           (clk),
        .reset_N       (reset_N),
        .active_i      (state_q == ST_DRAIN),
        .entry_i       (dr_ent),
        .vld_vec_i     (vld_vec),
        .out_ready_i   (out_ready),
        .scan_row_o    (scan_row),
        .scan_pe_o     (scan_pe),
        .out_valid_o   (out_valid),
        .out_last_o    (out_last),
        .out_row_o     (out_row),
        .out_pe_o      (out_pe),
        .out_score_o   (out_score),
        .out_id_o      (out_id),
        .out_pointer_o (out_pointer),
        .done_o        (drain_done)
    );

    assign start_cr     = start_cr_q;
    assign busy         = (state_q != ST_IDLE);
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_oflow_score_board.sv
// Directed bench for oflow_score_board: stimulus queues expected drained entries,
// a negedge monitor pops and compares them on every handshake.
module tb_oflow_score_board;
    import oflow_score_board_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset_N;
    logic                 start_fill, wr_valid, fill_done, start_cr;
    logic [ROW_LEN-1:0]   wr_row, row_sel, row_to_change, out_row;
    logic [PE_LEN-1:0]    wr_pe, pe_sel, pe_to_change, out_pe;
    logic [SCORE_LEN-1:0] wr_score, score_to_cr, out_score;
    logic [ID_LEN-1:0]    wr_id, id_to_cr, data_id, out_id;
    logic                 data_ptr, write_to_pointer, write_to_id;
    logic                 done_cr, th, out_valid, out_ready, out_pointer, out_last;
    logic                 busy, overflow_err;

    int checks   = 0;
    int failures = 0;
    int n;
    logic [17:0] exp_q [$];
    logic [17:0] held;
    logic        hold_pend = 1'b0;

    always #5 clk = ~clk;

    oflow_score_board dut (
        .clk(clk), .reset_N(reset_N), .start_fill(start_fill),
        .wr_valid(wr_valid), .wr_row(wr_row), .wr_pe(wr_pe), .wr_score(wr_score), .wr_id(wr_id),
        .fill_done(fill_done), .start_cr(start_cr),
        .row_sel(row_sel), .pe_sel(pe_sel), .score_to_cr(score_to_cr), .id_to_cr(id_to_cr),
        .row_to_change(row_to_change), .pe_to_change(pe_to_change),
        .data_to_score_board_from_cr_pointer(data_ptr), .write_to_pointer(write_to_pointer),
        .data_to_score_board_from_cr_id(data_id), .write_to_id(write_to_id),
        .done_cr(done_cr), .conflict_counter_th(th),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_pe(out_pe),
        .out_score(out_score), .out_id(out_id), .out_pointer(out_pointer), .out_last(out_last),
        .busy(busy), .overflow_err(overflow_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int r, input int p, input int s, input int id);
        wr_valid = 1'b1;
        wr_row   = ROW_LEN'(r);
        wr_pe    = PE_LEN'(p);
        wr_score = SCORE_LEN'(s);
        wr_id    = ID_LEN'(id);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_fill_done_and_resolve(input logic ovf);
        fill_done = 1'b1;
        step();
        fill_done = 1'b0;
        done_cr = 1'b1;
        th      = ovf;
        step();
        done_cr = 1'b0;
        th      = 1'b0;
    endtask

    task automatic rd(input string name, input int r, input int p, input int s, input int id);
        row_sel = ROW_LEN'(r);
        pe_sel  = PE_LEN'(p);
        #1;
        chk({name, "_score"}, 32'(score_to_cr), 32'(s));
        chk({name, "_id"}, 32'(id_to_cr), 32'(id));
    endtask

    // Output monitor: compares each accepted entry and checks hold stability under backpressure.
    initial begin
        logic [17:0] cur;
        logic [17:0] e;
        forever begin
            @(negedge clk);
            cur = {out_row, out_pe, out_score, out_id, out_pointer, out_last};
            if (hold_pend) begin
                checks++;
                if (!out_valid || cur !== held) begin
                    failures++;
                    $display("FAIL hold_stable actual=%0h valid=%0b expected=%0h", cur, out_valid, held);
                end
            end
            hold_pend = 1'b0;
            if (out_valid && !out_ready) begin
                hold_pend = 1'b1;
                held      = cur;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output actual=%0h expected=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        failures++;
                        $display("FAIL drain_entry actual=%0h expected=%0h", cur, e);
                    end
                end
            end
        end
    end

    initial begin
        reset_N = 1'b0; start_fill = 0; wr_valid = 0; wr_row = 0; wr_pe = 0; wr_score = 0; wr_id = 0;
        fill_done = 0; row_sel = 0; pe_sel = 0; row_to_change = 0; pe_to_change = 0;
        data_ptr = 0; write_to_pointer = 0; data_id = 0; write_to_id = 0;
        done_cr = 0; th = 0; out_ready = 0;
        step(); step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_start_cr", 32'(start_cr), 0);
        chk("rst_overflow", 32'(overflow_err), 0);
        reset_N = 1'b1;
        step();

        // Fill two entries plus out-of-range writes that must vanish
        start_fill = 1'b1; step(); start_fill = 1'b0;
        chk("fill_busy", 32'(busy), 1);
        wr(0, 0, 5, 3);
        wr(1, 2, 9, 7);
        wr(0, 3, 1, 1);
        wr(3, 0, 1, 1);
        rd("rd_1_2", 1, 2, 9, 7);
        rd("rd_0_1", 0, 1, 255, 0);
        rd("rd_3_0", 3, 0, 255, 0);
        fill_done = 1'b1; step(); fill_done = 1'b0;
        chk("start_cr_hi", 32'(start_cr), 1);
        step();
        chk("start_cr_lo", 32'(start_cr), 0);

        // Resolve: simultaneous pointer+id write, read returns pre-write value this cycle
        row_to_change = 0; pe_to_change = 0;
        data_ptr = 1'b1; write_to_pointer = 1'b1; data_id = 4'd12; write_to_id = 1'b1;
        rd("rd_prewrite", 0, 0, 5, 3);
        step();
        write_to_pointer = 1'b0; write_to_id = 1'b0;
        rd("rd_postwrite", 0, 0, 5, 12);
        row_to_change = 0; pe_to_change = 1; data_id = 4'd5; write_to_id = 1'b1;
        step();
        write_to_id = 1'b0;
        rd("rd_cr_invalid", 0, 1, 255, 0);
        wr(1, 2, 1, 1);
        rd("rd_wr_outside_fill", 1, 2, 9, 7);

        // Drain with backpressure; start_fill here must be ignored
        exp_q.push_back({2'd0, 2'd0, 8'd5, 4'd12, 1'b1, 1'b0});
        exp_q.push_back({2'd1, 2'd2, 8'd9, 4'd7, 1'b0, 1'b1});
        done_cr = 1'b1; step(); done_cr = 1'b0;
        step();
        chk("drain_valid_up", 32'(out_valid), 1);
        start_fill = 1'b1; step(); start_fill = 1'b0;
        chk("drain_ignore_start", 32'(busy), 1);
        step();
        out_ready = 1'b1;
        n = 0;
        while (busy && n < 40) begin step(); n++; end
        chk("drain_to_idle", 32'(busy), 0);
        chk("drain_all_seen", 32'(exp_q.size()), 0);

        // Overflow path
        start_fill = 1'b1; step(); start_fill = 1'b0;
        wr(2, 1, 4, 2);
        pulse_fill_done_and_resolve(1'b1);
        chk("ovf_idle", 32'(busy), 0);
        chk("ovf_err", 32'(overflow_err), 1);
        chk("ovf_no_valid", 32'(out_valid), 0);
        step(); step();
        start_fill = 1'b1; step(); start_fill = 1'b0;
        chk("ovf_cleared", 32'(overflow_err), 0);

        // Empty board: the earlier (2,1) entry must have been cleared by start_fill
        rd("rd_cleared", 2, 1, 255, 0);
        pulse_fill_done_and_resolve(1'b0);
        n = 0;
        while (busy && n < 40) begin step(); n++; end
        chk("empty_idle", 32'(busy), 0);
        chk("empty_bound", 32'(n <= 11), 1);

        // Reset during drain after the first handshake
        start_fill = 1'b1; step(); start_fill = 1'b0;
        wr(0, 1, 1, 1);
        wr(2, 2, 2, 2);
        exp_q.push_back({2'd0, 2'd1, 8'd1, 4'd1, 1'b0, 1'b0});
        pulse_fill_done_and_resolve(1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin step(); n++; end
        chk("first_hs_seen", 32'(exp_q.size()), 0);
        reset_N = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_last", 32'(out_last), 0);
        step();
        reset_N = 1'b1;
        step();
        rd("rd_after_rst", 2, 2, 255, 0);
        start_fill = 1'b1; step(); start_fill = 1'b0;
        pulse_fill_done_and_resolve(1'b0);
        n = 0;
        while (busy && n < 40) begin step(); n++; end
        chk("redrain_idle", 32'(busy), 0);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oflow_score_board.md
OFLOW_SCORE_BOARD -- requirements
Module: oflow_score_board

Interface
REQ-001 Parameter ROWS, default `MAX_ROWS_IN_SCORE_BOARD, number of score-board rows.
REQ-002 Parameter PES, default `PE_NUM, entries per row (pe index 0..PES-1).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset_N  in  1  asynchronous, active-low reset.
REQ-005 start_fill  in  1  pulse: clear board, enter FILL.
REQ-006 wr_valid / wr_row / wr_pe / wr_score / wr_id  in  1/`ROW_LEN/`PE_LEN/`SCORE_LEN/`ID_LEN  PE result write.
REQ-007 fill_done  in  1  pulse: PE results complete.
REQ-008 start_cr  out  1  one-cycle pulse to conflict-resolve FSM.
REQ-009 row_sel / pe_sel  in  `ROW_LEN/`PE_LEN  CR read address; score_to_cr / id_to_cr  out  `SCORE_LEN/`ID_LEN  read data.
REQ-010 row_to_change / pe_to_change / data_to_score_board_from_cr_pointer / write_to_pointer  in  `ROW_LEN/`PE_LEN/1/1  pointer write-back.
REQ-011 data_to_score_board_from_cr_id / write_to_id  in  `ID_LEN/1  id write-back (same row/pe address).
REQ-012 done_cr / conflict_counter_th  in  1/1  CR completion, CR overflow flag.
REQ-013 out_valid / out_ready  out/in  1/1  drain handshake; out_row, out_pe, out_score, out_id, out_pointer, out_last  out  matching widths, drained entry.
REQ-014 busy, overflow_err  out  1/1  status.

Function
REQ-015 Storage SHALL be ROWS x PES entries of {valid, score, id, pointer}.
REQ-016 States SHALL be IDLE, FILL, RESOLVE, DRAIN; IDLE->FILL on start_fill; FILL->RESOLVE on fill_done; RESOLVE->DRAIN on done_cr with conflict_counter_th=0; RESOLVE->IDLE on done_cr with conflict_counter_th=1; DRAIN->IDLE after the handshake carrying out_last.
REQ-017 Entering FILL SHALL clear all valid and pointer bits in one cycle.
REQ-018 In FILL, wr_valid SHALL write score/id, set valid, clear pointer at [wr_row][wr_pe] next edge; wr_valid outside FILL SHALL be ignored; out-of-range row/pe SHALL be ignored.
REQ-019 start_cr SHALL pulse exactly one cycle, the cycle after the FILL->RESOLVE transition.
REQ-020 Read port SHALL be combinational, zero latency: valid entry returns stored score/id; invalid or out-of-range entry returns id 0 and score all-ones.
REQ-021 In RESOLVE, write_to_pointer SHALL write the pointer bit and write_to_id SHALL overwrite id at [row_to_change][pe_to_change] next edge; both in one cycle SHALL both apply; writes to invalid entries SHALL be ignored; CR writes outside RESOLVE SHALL be ignored.
REQ-022 A CR write and a CR read to the same entry in one cycle SHALL return the pre-write value.
REQ-023 DRAIN SHALL emit valid entries only, row-major (row 0 pe 0 first), one per accepted handshake; invalid entries skipped at one per cycle with out_valid=0.
REQ-024 out_valid SHALL hold and outputs stay stable until out_ready; out_last SHALL mark the final valid entry; a board with no valid entries SHALL return to IDLE without asserting out_valid.
REQ-025 overflow_err SHALL set on done_cr with conflict_counter_th=1 and clear on next start_fill.
REQ-026 busy SHALL be 1 in every state except IDLE; start_fill outside IDLE SHALL be ignored.
REQ-027 Drain scan counter SHALL use `ROW_LEN+`PE_LEN bits and terminate at ROWS*PES without wrap.

Reset
REQ-028 reset_N low SHALL force IDLE, clear all valid/pointer bits, and drive start_cr, out_valid, out_last, busy, overflow_err to 0.
REQ-029 Reset mid-FILL, RESOLVE, or DRAIN SHALL abort immediately; no partial entry SHALL be drained afterward.

Structure
REQ-030 State enum, entry struct, and ROWS/PES defaults SHALL live in the shared oflow_core package/define file.
REQ-031 One sub-module oflow_score_board_drain (scan counter plus valid/ready output register) SHALL implement DRAIN.

Verification
REQ-032 Fill [0][0]=(score 5,id 3),[1][2]=(9,7), fill_done -> start_cr one pulse; read (1,2) returns 9/7; read (0,1) returns id 0, score all-ones.
REQ-033 RESOLVE: write_to_pointer=1 data 1 and write_to_id=1 id 12 at (0,0) same cycle -> next-cycle read id 12; drained pointer=1.
REQ-034 Drain with out_ready low 3 cycles -> out_valid held, data stable; entries (0,0) then (1,2), out_last only on (1,2).
REQ-035 done_cr with conflict_counter_th=1 -> IDLE, overflow_err=1, no out_valid; next start_fill clears overflow_err.
REQ-036 Empty board drain -> IDLE within ROWS*PES+2 cycles, out_valid never high.
REQ-037 reset_N low during DRAIN after first handshake -> IDLE, outputs 0, re-drain without fill emits nothing.
